// File: rtl/onetoeig_demux_pkg.sv
// Shared types and constants for the 1-to-8 time-division demux.
// Imported by the slot counter and the top.
package onetoeig_demux_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;

endpackage

// File: rtl/onetoeig_demux_slot_ctr.sv
// 3-bit slot counter: sync restarts at slot 1, valid beats advance.
// wrap flags the beat that completes a frame.
module onetoeig_demux_slot_ctr
    import onetoeig_demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    output logic [SLOT_W-1:0] slot,
    output logic              wrap
);

    logic [SLOT_W-1:0] slot_q;

    // Counter register; load has priority over a plain increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else if (load) begin
            slot_q <= SLOT_W'(1);
        end else if (en) begin
            slot_q <= slot_q + 1'b1;
        end
    end

    assign slot = slot_q;
    assign wrap = en & ~load & (slot_q == SLOT_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/onetoeig_demux.sv
// Registered 1-to-8 time-division demultiplexer with frame capture.
// A sync-qualified beat aligns the slot counter to slot 0.
module onetoeig_demux
    import onetoeig_demux_pkg::*;
#(
    parameter int DATA_W     = 1,
    parameter bit HOLD_UNSEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_valid,
    input  logic                  sync,
    output logic [DATA_W-1:0]     d0,
    output logic [DATA_W-1:0]     d1,
    output logic [DATA_W-1:0]     d2,
    output logic [DATA_W-1:0]     d3,
    output logic [DATA_W-1:0]     d4,
    output logic [DATA_W-1:0]     d5,
    output logic [DATA_W-1:0]     d6,
    output logic [DATA_W-1:0]     d7,
    output logic [SLOT_W-1:0]     slot,
    output logic                  locked,
    output logic [8*DATA_W-1:0]   frame_word,
    output logic                  frame_valid,
    output logic                  sync_err
);

    state_t state_q;
    state_t state_d;

    logic                 beat_sync;
    logic                 run_beat;
    logic                 wr_en;
    logic                 wrap;
    logic [SLOT_W-1:0]    wr_idx;
    logic [NUM_SLOTS-1:0] lane_we;
    logic [DATA_W-1:0]    d_q   [NUM_SLOTS];
    logic [DATA_W-1:0]    acc_q [NUM_SLOTS];
    logic [8*DATA_W-1:0]  frame_next;

    assign beat_sync = din_valid & sync;
    assign run_beat  = din_valid & (state_q == RUN);
    assign wr_en     = beat_sync | run_beat;
    assign wr_idx    = beat_sync ? '0 : slot;

    onetoeig_demux_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (beat_sync),
        .en    (run_beat),
        .slot  (slot),
        .wrap  (wrap)
    );

    // Alignment state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Any sync-qualified beat acquires (or keeps) alignment.
    always_comb begin
        state_d = state_q;
        if (beat_sync) begin
            state_d = RUN;
        end
    end

    // One-hot lane write-enable for the slot being written.
    always_comb begin
        lane_we = '0;
        if (wr_en) begin
            lane_we[wr_idx] = 1'b1;
        end
    end

    // Per-slot outputs; optionally clear unselected lanes on a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (lane_we[i]) begin
                    d_q[i] <= din;
                end else if (wr_en && !HOLD_UNSEL) begin
                    d_q[i] <= '0;
                end
            end
        end
    end

    // Frame accumulator keeps every slot so capture is independent of clearing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (lane_we[i]) begin
                    acc_q[i] <= din;
                end
            end
        end
    end

    // Assemble the completed frame with the slot-7 beat taken from din.
    always_comb begin
        frame_next = '0;
        for (int i = 0; i < NUM_SLOTS - 1; i++) begin
            frame_next[i*DATA_W +: DATA_W] = acc_q[i];
        end
        frame_next[(NUM_SLOTS-1)*DATA_W +: DATA_W] = din;
    end

    // Frame capture, frame strobe and resync error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_word  <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= wrap;
            sync_err    <= beat_sync & (state_q == RUN) & (slot != '0);
            if (wrap) begin
                frame_word <= frame_next;
            end
        end
    end

    assign d0     = d_q[0];
    assign d1     = d_q[1];
    assign d2     = d_q[2];
    assign d3     = d_q[3];
    assign d4     = d_q[4];
    assign d5     = d_q[5];
    assign d6     = d_q[6];
    assign d7     = d_q[7];
    assign locked = (state_q == RUN);

endmodule

// File: tb/tb_onetoeig_demux.sv
// Bench for onetoeig_demux: two instances (1-bit hold, 4-bit clear)
// driven in lockstep and compared to a slot/frame reference model.
module tb_onetoeig_demux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din_valid;
    logic       sync;
    logic [3:0] din;

    always #5 clk = ~clk;

    logic [0:0] a_d [8];
    logic [2:0] a_slot;
    logic       a_lock;
    logic [7:0] a_fw;
    logic       a_fv;
    logic       a_se;

    logic [3:0]  b_d [8];
    logic [2:0]  b_slot;
    logic        b_lock;
    logic [31:0] b_fw;
    logic        b_fv;
    logic        b_se;

    onetoeig_demux #(.DATA_W(1), .HOLD_UNSEL(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din[0:0]),
        .din_valid(din_valid), .sync(sync),
        .d0(a_d[0]), .d1(a_d[1]), .d2(a_d[2]), .d3(a_d[3]),
        .d4(a_d[4]), .d5(a_d[5]), .d6(a_d[6]), .d7(a_d[7]),
        .slot(a_slot), .locked(a_lock), .frame_word(a_fw),
        .frame_valid(a_fv), .sync_err(a_se)
    );

    onetoeig_demux #(.DATA_W(4), .HOLD_UNSEL(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din),
        .din_valid(din_valid), .sync(sync),
        .d0(b_d[0]), .d1(b_d[1]), .d2(b_d[2]), .d3(b_d[3]),
        .d4(b_d[4]), .d5(b_d[5]), .d6(b_d[6]), .d7(b_d[7]),
        .slot(b_slot), .locked(b_lock), .frame_word(b_fw),
        .frame_valid(b_fv), .sync_err(b_se)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model, index 0 = u0, index 1 = u1.
    int          mw   [2] = '{1, 4};
    bit          mhold[2] = '{1'b1, 1'b0};
    logic [3:0]  m_d  [2][8];
    logic [3:0]  m_acc[2][8];
    bit          m_lock[2];
    int          m_slot[2];
    logic [31:0] m_fw [2];
    bit          m_fv [2];
    bit          m_se [2];

    function automatic logic [31:0] pack_model(int m, bit use_acc);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r = r | ((use_acc ? 32'(m_acc[m][i]) : 32'(m_d[m][i])) << (i * mw[m]));
        end
        return r;
    endfunction

    task automatic model_clk();
        for (int m = 0; m < 2; m++) begin
            logic [3:0] v;
            int tgt;
            int nslot;
            v     = (mw[m] == 1) ? (din & 4'h1) : din;
            tgt   = -1;
            nslot = m_slot[m];
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) begin
                    m_d[m][i]   = '0;
                    m_acc[m][i] = '0;
                end
                m_lock[m] = 0; m_slot[m] = 0; m_fw[m] = '0;
                m_fv[m] = 0; m_se[m] = 0;
            end else begin
                m_fv[m] = 0;
                m_se[m] = 0;
                if (din_valid) begin
                    if (sync) begin
                        if (m_lock[m] && m_slot[m] != 0) m_se[m] = 1;
                        tgt = 0; nslot = 1; m_lock[m] = 1;
                    end else if (m_lock[m]) begin
                        tgt = m_slot[m]; nslot = (m_slot[m] + 1) % 8;
                    end
                end
                if (tgt >= 0) begin
                    if (!mhold[m]) begin
                        for (int i = 0; i < 8; i++) m_d[m][i] = '0;
                    end
                    m_d[m][tgt]   = v;
                    m_acc[m][tgt] = v;
                    if (tgt == 7) begin
                        m_fv[m] = 1;
                        m_fw[m] = pack_model(m, 1'b1);
                    end
                    m_slot[m] = nslot;
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] av;
        logic [31:0] bv;
        av = '0;
        bv = '0;
        for (int i = 0; i < 8; i++) begin
            av = av | (32'(a_d[i]) << i);
            bv = bv | (32'(b_d[i]) << (4 * i));
        end
        chk("u0_dvec", av, pack_model(0, 1'b0));
        chk("u0_slot", 32'(a_slot), 32'(m_slot[0]));
        chk("u0_locked", 32'(a_lock), 32'(m_lock[0]));
        chk("u0_frame_word", 32'(a_fw), m_fw[0]);
        chk("u0_frame_valid", 32'(a_fv), 32'(m_fv[0]));
        chk("u0_sync_err", 32'(a_se), 32'(m_se[0]));
        chk("u1_dvec", bv, pack_model(1, 1'b0));
        chk("u1_slot", 32'(b_slot), 32'(m_slot[1]));
        chk("u1_locked", 32'(b_lock), 32'(m_lock[1]));
        chk("u1_frame_valid", 32'(b_fv), 32'(m_fv[1]));
        chk("u1_sync_err", 32'(b_se), 32'(m_se[1]));
        chk("u0_pulse_excl", 32'(a_fv & a_se), 32'd0);
    endtask

    task automatic step(bit v, bit s, logic [3:0] d);
        din_valid = v;
        sync      = s;
        din       = d;
        @(posedge clk);
        model_clk();
        #1;
        check_all();
    endtask

    logic [7:0] pat;
    int fv_seen;

    initial begin
        pat = 8'h4D;
        rst_n = 1'b0; din_valid = 1'b0; sync = 1'b0; din = '0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 8; i++) begin
                m_d[m][i] = '0; m_acc[m][i] = '0;
            end
            m_lock[m] = 0; m_slot[m] = 0; m_fw[m] = '0;
            m_fv[m] = 0; m_se[m] = 0;
        end

        // Reset with toggling inputs.
        for (int i = 0; i < 3; i++) step(i[0], 1'b1, 4'(i + 5));
        chk("t1_locked", 32'(a_lock), 32'd0);
        chk("t1_frame", 32'(a_fw), 32'd0);
        rst_n = 1'b1;

        // HUNT ignores beats without sync.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'hF);
        chk("t2_hunt_d0", 32'(a_d[0]), 32'd0);
        chk("t2_hunt_locked", 32'(a_lock), 32'd0);
        step(1'b0, 1'b1, 4'h1);
        chk("t2_sync_novalid", 32'(a_lock), 32'd0);
        step(1'b1, 1'b1, 4'h1);
        chk("t2_d0", 32'(a_d[0]), 32'd1);
        chk("t2_slot", 32'(a_slot), 32'd1);
        chk("t2_locked", 32'(a_lock), 32'd1);

        // Full frame 1,0,1,1,0,0,1,0 on slots 0..7.
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, {3'b0, pat[i]});
        chk("t3_frame_word", 32'(a_fw), 32'h4D);
        chk("t3_frame_valid", 32'(a_fv), 32'd1);
        chk("t3_slot", 32'(a_slot), 32'd0);
        step(1'b0, 1'b0, 4'h0);
        chk("t3_pulse_once", 32'(a_fv), 32'd0);

        // Same frame with two idle cycles between beats.
        fv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, {3'b0, pat[i]});
            if (i < 7) begin
                fv_seen += int'(a_fv);
                step(1'b0, 1'b0, 4'h0);
                fv_seen += int'(a_fv);
                step(1'b0, 1'b0, 4'h0);
                fv_seen += int'(a_fv);
            end
        end
        chk("t4_frame_word", 32'(a_fw), 32'h4D);
        chk("t4_frame_valid", 32'(a_fv), 32'd1);
        chk("t4_no_extra", 32'(fv_seen), 32'd0);

        // Resync at slot 3.
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b0, 4'h0);
        chk("t5_slot3", 32'(a_slot), 32'd3);
        step(1'b1, 1'b1, 4'h0);
        chk("t5_sync_err", 32'(a_se), 32'd1);
        chk("t5_no_frame", 32'(a_fv), 32'd0);
        chk("t5_d0", 32'(a_d[0]), 32'd0);
        chk("t5_slot", 32'(a_slot), 32'd1);
        step(1'b0, 1'b0, 4'h0);
        chk("t5_err_once", 32'(a_se), 32'd0);

        // Clearing instance: A at slot 2, then reset at slot 5.
        step(1'b1, 1'b1, 4'h3);
        step(1'b1, 1'b0, 4'h5);
        step(1'b1, 1'b0, 4'hA);
        chk("t6_dvec", {b_d[7], b_d[6], b_d[5], b_d[4],
                        b_d[3], b_d[2], b_d[1], b_d[0]}, 32'h0000_0A00);
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'h9);
        chk("t6_slot5", 32'(b_slot), 32'd5);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 4'hC);
        chk("t6_rst_locked", 32'(b_lock), 32'd0);
        chk("t6_rst_d3", 32'(b_d[3]), 32'd0);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0,
                 4'($urandom));
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
